// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one six-plane VRAM array (six 8K x 8 synchronous RAMs with a common
// address and write data bus) between the CPU and the video fetch engine.
// Each access is ACC (RAM cycle) followed by RD (read data valid), so at most
// one access completes every two cycles. Video normally wins a simultaneous
// request. A starvation counter lets the CPU win once it has been refused
// STARVE times in a row. The requester being acked is excluded from the
// re-arbitration on that same edge, which makes continuous contention
// alternate V,C,V,C.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   cpu_req/we/addr/din/rd_mask/wr_mask
//                     CPU request (level, held until cpu_ack) and the fields
//                     sampled at grant
//   cpu_dout, cpu_ack read data (OR of selected planes) with a 1-cycle ack
//   cpu_wait_n        combinational Z80 wait line, low while a request waits
//   vid_req, vid_addr video fetch request (level, held until vid_ack)
//   vid_data, vid_ack all six plane bytes {plane6..plane1} with a 1-cycle ack
//   mem_addr/we/din   registered RAM controls (per-plane write enables)
//   mem_q             RAM read data, one cycle after mem_addr
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int AW     = 13,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic [5:0]    cpu_rd_mask,
    input  logic [5:0]    cpu_wr_mask,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic          cpu_wait_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [47:0]   vid_data,
    output logic          vid_ack,
    output logic [AW-1:0] mem_addr,
    output logic [5:0]    mem_we,
    output logic [7:0]    mem_din,
    input  logic [47:0]   mem_q
);

    localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RD} state_t;
    typedef enum logic {OWN_VID, OWN_CPU} owner_t;

    state_t        state;
    owner_t        owner;
    logic          owner_we;     // current CPU access is a write
    logic [5:0]    rd_mask_q;    // read-bank mask latched at grant
    logic [SW-1:0] starve_cnt;

    logic cpu_elig, vid_elig;
    logic grant_cpu, grant_vid;
    logic acking_cpu;
    logic [7:0] rd_or;

    // Arbitration happens from IDLE and on the RD edge; on the RD edge the
    // owner being acked still shows req=1 and must not be granted again.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        cpu_elig = 1'b0;
        vid_elig = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_elig = cpu_req;
                vid_elig = vid_req;
            end
            S_RD: begin
                cpu_elig = cpu_req && (owner != OWN_CPU);
                vid_elig = vid_req && (owner != OWN_VID);
            end
            default: ;
        endcase
        grant_cpu  = cpu_elig && (!vid_elig || (starve_cnt == STARVE_MAX));
        grant_vid  = vid_elig && !grant_cpu;
        acking_cpu = (state == S_RD) && (owner == OWN_CPU);
    end

    // CPU read data: OR of the plane bytes enabled in the read-bank mask.
    always_comb begin
        rd_or = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (rd_mask_q[i]) rd_or = rd_or | mem_q[8*i +: 8];
        end
    end

    assign cpu_wait_n = ~(cpu_req & ~cpu_ack);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= OWN_VID;
            owner_we   <= 1'b0;
            rd_mask_q  <= 6'h00;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_we     <= 6'h00;
            mem_din    <= 8'h00;
            cpu_dout   <= 8'h00;
            vid_data   <= 48'h0;
            cpu_ack    <= 1'b0;
            vid_ack    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;

            // Consecutive edges the CPU has been refused.
            if (!cpu_req || grant_cpu)
                starve_cnt <= '0;
            else if (!acking_cpu && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);

            case (state)
                S_ACC: begin
                    mem_we <= 6'h00;          // exactly one write cycle
                    state  <= S_RD;
                end
                S_RD: begin
                    if (owner == OWN_CPU) begin
                        cpu_ack  <= 1'b1;
                        cpu_dout <= owner_we ? 8'h00 : rd_or;
                    end else begin
                        vid_ack  <= 1'b1;
                        vid_data <= mem_q;
                    end
                    state <= S_IDLE;
                end
                default: ;
            endcase

            // A grant (from IDLE or on the RD edge) overrides the next state.
            if (grant_cpu) begin
                state     <= S_ACC;
                owner     <= OWN_CPU;
                owner_we  <= cpu_we;
                rd_mask_q <= cpu_rd_mask;
                mem_addr  <= cpu_addr;
                mem_we    <= cpu_we ? cpu_wr_mask : 6'h00;
                if (cpu_we) mem_din <= cpu_din;
            end else if (grant_vid) begin
                state     <= S_ACC;
                owner     <= OWN_VID;
                owner_we  <= 1'b0;
                mem_addr  <= vid_addr;
                mem_we    <= 6'h00;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Bench for vram_arbiter. A behavioural six-plane synchronous RAM hangs off
// the mem_* bus. Expected read results are pushed to per-requester queues when
// a request is driven and popped by a monitor when the matching ack appears.
// Scenario tasks check timing (grant, write-enable width, latency, ordering).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int AW       = 13;
    localparam int STARVE   = 4;
    localparam int IDLE_LAT = 3;   // falling edges from request to ack: E0,E1,E2
    localparam int BUDGET   = 30;
    localparam logic [47:0] VID_PAT = 48'h010203040506;

    logic          clk;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [5:0]    cpu_rd_mask, cpu_wr_mask;
    logic [7:0]    cpu_dout;
    logic          cpu_ack, cpu_wait_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [47:0]   vid_data;
    logic          vid_ack;
    logic [AW-1:0] mem_addr;
    logic [5:0]    mem_we;
    logic [7:0]    mem_din;
    logic [47:0]   mem_q;

    int errors = 0;
    int checks = 0;

    logic [7:0]  cpu_exp_q[$];
    logic [47:0] vid_exp_q[$];

    logic [7:0] ram    [6][1<<AW];
    logic [7:0] shadow [6][1<<AW];

    vram_arbiter #(.AW(AW), .STARVE(STARVE)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_rd_mask(cpu_rd_mask), .cpu_wr_mask(cpu_wr_mask),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_ack(vid_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Six synchronous planes, one cycle read latency, shared address/data.
    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (mem_we[i] === 1'b1) ram[i][mem_addr] <= mem_din;
            mem_q[8*i +: 8] <= ram[i][mem_addr];
        end
    end

    // Scoreboard monitor: every ack must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (cpu_ack === 1'b1) begin
                checks++;
                if (cpu_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_unexpected_ack: cpu_dout=%h with nothing pending", cpu_dout);
                end else begin
                    logic [7:0] e;
                    e = cpu_exp_q.pop_front();
                    if (cpu_dout !== e) begin
                        errors++;
                        $display("FAIL cpu_dout: got %h expected %h", cpu_dout, e);
                    end
                end
            end
            if (vid_ack === 1'b1) begin
                checks++;
                if (vid_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL vid_unexpected_ack: vid_data=%h with nothing pending", vid_data);
                end else begin
                    logic [47:0] e;
                    e = vid_exp_q.pop_front();
                    if (vid_data !== e) begin
                        errors++;
                        $display("FAIL vid_data: got %h expected %h", vid_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_read(input logic [AW-1:0] a, input logic [5:0] m);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 6; i++) if (m[i]) r = r | shadow[i][a];
        return r;
    endfunction

    // Drive a CPU request at the current falling edge and record its result.
    task automatic cpu_issue(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                             input logic [5:0] wm, input logic [5:0] rm);
        cpu_we = we; cpu_addr = a; cpu_din = d; cpu_wr_mask = wm; cpu_rd_mask = rm;
        cpu_req = 1'b1;
        if (we) begin
            for (int i = 0; i < 6; i++) if (wm[i]) shadow[i][a] = d;
            cpu_exp_q.push_back(8'h00);
        end else begin
            cpu_exp_q.push_back(exp_read(a, rm));
        end
    endtask

    task automatic wait_cpu_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_ack !== 1'b1 && n < BUDGET);
        if (cpu_ack !== 1'b1) begin
            checks++; errors++;
            $display("FAIL cpu_ack_timeout: no ack after %0d cycles, required within %0d", n, BUDGET);
        end
    endtask

    task automatic wait_vid_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vid_ack !== 1'b1 && n < BUDGET);
        if (vid_ack !== 1'b1) begin
            checks++; errors++;
            $display("FAIL vid_ack_timeout: no ack after %0d cycles, required within %0d", n, BUDGET);
        end
    endtask

    // One isolated CPU access from idle, checking latency and pulse width.
    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                              input logic [5:0] wm, input logic [5:0] rm);
        int n;
        cpu_issue(we, a, d, wm, rm);
        wait_cpu_ack(n);
        cpu_req = 1'b0;
        checks++;
        if (n != IDLE_LAT) begin
            errors++;
            $display("FAIL cpu_latency: got %0d expected %0d (addr %h)", n, IDLE_LAT, a);
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL cpu_ack_width: ack still %b one cycle later, expected 0", cpu_ack);
        end
    endtask

    // Back-to-back requests with req held high between them.
    task automatic vid_stream(input logic [AW-1:0] a, input int count);
        int n;
        vid_addr = a; vid_req = 1'b1;
        vid_exp_q.push_back(VID_PAT);
        for (int i = 0; i < count; i++) begin
            wait_vid_ack(n);
            if (i == count - 1) vid_req = 1'b0;
            else vid_exp_q.push_back(VID_PAT);
        end
    endtask

    task automatic cpu_stream(input logic [AW-1:0] a, input logic [5:0] rm, input int count);
        int n;
        cpu_issue(1'b0, a, 8'h00, 6'h00, rm);
        for (int i = 0; i < count; i++) begin
            wait_cpu_ack(n);
            if (i == count - 1) cpu_req = 1'b0;
            else cpu_exp_q.push_back(exp_read(a, rm));
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        cpu_we = 1'b0; cpu_addr = 13'h0040; cpu_din = 8'h00;
        cpu_rd_mask = 6'h00; cpu_wr_mask = 6'h00; cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_addr, mem_we, mem_din, cpu_dout, vid_data, cpu_ack, vid_ack} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%h we=%h din=%h dout=%h vdata=%h acks=%b%b expected all 0",
                     mem_addr, mem_we, mem_din, cpu_dout, vid_data, cpu_ack, vid_ack);
        end
        checks++;
        if (cpu_wait_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait_n: got %b expected 0", cpu_wait_n);
        end
        cpu_exp_q.push_back(exp_read(13'h0040, 6'h00));
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== 13'h0040) begin
            errors++;
            $display("FAIL reset_release_grant: mem_addr=%h expected 0040", mem_addr);
        end
        wait_cpu_ack(n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL reset_release_latency: ack after %0d more cycles, expected 2", n);
        end
        checks++;
        if (cpu_wait_n !== 1'b1) begin
            errors++;
            $display("FAIL wait_n_during_ack: got %b expected 1", cpu_wait_n);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0 || cpu_wait_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_ack_width: ack=%b wait_n=%b expected 0/1", cpu_ack, cpu_wait_n);
        end
    endtask

    task automatic test_cpu_write_read();
        int n;
        cpu_access(1'b1, 13'h0123, 8'h3C, 6'h02, 6'h00);   // plane 2 byte
        cpu_issue(1'b1, 13'h0123, 8'hA5, 6'h05, 6'h00);
        @(negedge clk);
        checks++;
        if (mem_we !== 6'h05 || mem_addr !== 13'h0123 || mem_din !== 8'hA5) begin
            errors++;
            $display("FAIL write_grant: we=%h addr=%h din=%h expected 05/0123/a5", mem_we, mem_addr, mem_din);
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 6'h00) begin
            errors++;
            $display("FAIL write_width: mem_we=%h in RD cycle, expected 00", mem_we);
        end
        wait_cpu_ack(n);
        cpu_req = 1'b0;
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL write_latency: ack %0d cycles after RD, expected 1", n);
        end
        @(negedge clk);
        cpu_access(1'b0, 13'h0123, 8'h00, 6'h00, 6'h05);   // 0xA5
        cpu_access(1'b0, 13'h0123, 8'h00, 6'h00, 6'h02);   // 0x3C
        // Write with an empty mask: no plane changes, still acked.
        cpu_issue(1'b1, 13'h0123, 8'hFF, 6'h00, 6'h00);
        @(negedge clk);
        checks++;
        if (mem_we !== 6'h00) begin
            errors++;
            $display("FAIL zero_mask_write: mem_we=%h expected 00", mem_we);
        end
        wait_cpu_ack(n);
        cpu_req = 1'b0;
        @(negedge clk);
        cpu_access(1'b0, 13'h0123, 8'h00, 6'h00, 6'h07);   // 0xA5|0x3C = 0xBD
    endtask

    task automatic test_video_read();
        int n;
        for (int k = 0; k < 6; k++)
            cpu_access(1'b1, 13'h1FFF, 8'(6 - k), 6'(1 << k), 6'h00);
        vid_addr = 13'h1FFF; vid_req = 1'b1;
        vid_exp_q.push_back(VID_PAT);
        wait_vid_ack(n);
        vid_req = 1'b0;
        checks++;
        if (n != IDLE_LAT) begin
            errors++;
            $display("FAIL vid_latency: got %0d expected %0d", n, IDLE_LAT);
        end
        checks++;
        if (mem_addr !== 13'h1FFF || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL vid_addr_path: mem_addr=%h cpu_ack=%b expected 1fff/0", mem_addr, cpu_ack);
        end
        @(negedge clk);
        checks++;
        if (vid_ack !== 1'b0) begin
            errors++;
            $display("FAIL vid_ack_width: ack %b one cycle later, expected 0", vid_ack);
        end
    endtask

    task automatic test_alternation();
        fork
            vid_stream(13'h1FFF, 4);
            cpu_stream(13'h0123, 6'h05, 4);
            begin : observe
                int acks;
                int gap;
                int cyc;
                logic last_cpu;
                acks = 0; gap = 0; cyc = 0; last_cpu = 1'b0;
                while (acks < 8 && cyc < 40) begin
                    @(negedge clk);
                    cyc++; gap++;
                    if (cpu_ack === 1'b1 || vid_ack === 1'b1) begin
                        checks++;
                        if (cpu_ack === 1'b1 && vid_ack === 1'b1) begin
                            errors++;
                            $display("FAIL alt_double_ack: both acks high at ack %0d", acks);
                        end else if (acks == 0 && vid_ack !== 1'b1) begin
                            errors++;
                            $display("FAIL alt_first_owner: got cpu expected video");
                        end else if (acks > 0 && (cpu_ack == last_cpu || gap != 2)) begin
                            errors++;
                            $display("FAIL alt_order: ack %0d cpu=%b prev_cpu=%b gap=%0d expected alternate, gap 2",
                                     acks, cpu_ack, last_cpu, gap);
                        end
                        last_cpu = cpu_ack;
                        acks++;
                        gap = 0;
                    end
                end
                checks++;
                if (acks != 8) begin
                    errors++;
                    $display("FAIL alt_count: got %0d acks expected 8", acks);
                end
            end
        join
        @(negedge clk);
    endtask

    task automatic test_starvation();
        fork
            vid_stream(13'h1FFF, 8);
            begin
                int n;
                repeat (6) @(negedge clk);   // lands on a video ack, colliding at IDLE
                cpu_issue(1'b0, 13'h0123, 8'h00, 6'h00, 6'h01);
                wait_cpu_ack(n);
                cpu_req = 1'b0;
                checks++;
                if (n < IDLE_LAT || n > STARVE + IDLE_LAT) begin
                    errors++;
                    $display("FAIL starve_latency: cpu ack after %0d cycles, expected %0d..%0d",
                             n, IDLE_LAT, STARVE + IDLE_LAT);
                end
            end
        join
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int acks;
        cpu_access(1'b1, 13'h0200, 8'h00, 6'h3F, 6'h00);   // known contents
        cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_din = 8'h77;
        cpu_wr_mask = 6'h3F; cpu_rd_mask = 6'h00; cpu_req = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 6'h3F) begin
            errors++;
            $display("FAIL abort_setup: mem_we=%h expected 3f", mem_we);
        end
        reset = 1'b1; cpu_req = 1'b0;
        #1;
        checks++;
        if (mem_we !== 6'h00 || mem_addr !== '0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: we=%h addr=%h ack=%b expected 00/0000/0", mem_we, mem_addr, cpu_ack);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack !== 1'b0 || vid_ack !== 1'b0 || mem_we !== 6'h00) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL abort_spurious: %0d cycles with ack or write, expected 0", acks);
        end
        cpu_access(1'b0, 13'h0200, 8'h00, 6'h00, 6'h3F);   // aborted write left planes at 0
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = 8'h00;
        cpu_rd_mask = 6'h00; cpu_wr_mask = 6'h00;
        vid_req = 1'b0; vid_addr = '0;
        test_reset();
        test_cpu_write_read();
        test_video_read();
        test_alternation();
        test_starvation();
        test_reset_mid_access();
        checks++;
        if (cpu_exp_q.size() != 0 || vid_exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: cpu=%0d vid=%0d still queued, expected 0",
                     cpu_exp_q.size(), vid_exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
